multi_channel_period_counter: RTL and testbench

//  NUM_CH-channel period counter: measures clock cycles between accepted rising edges on each ChA input.

---
 rtl/multi_channel_period_counter.sv | 171 +++++++++++++++++
 tb/tb_multi_channel_period_counter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_period_counter.sv
// Multi-channel period counter. Each channel measures the clock cycles between
// accepted rising edges on its pulse input. A glitch lockout rejects edges that
// come too soon after the last accepted one. An undersample ratio lets one
// record span several periods. Records from all channels share one FIFO write
// port through a round-robin arbiter.
module multi_channel_period_counter #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int MIN_GAP = 100,
   parameter int US_W    = 3,
   parameter int DROP_W  = 16,
   localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int DATA_W  = CH_BITS + 1 + CNT_W
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic [NUM_CH-1:0] ChA,
   input  logic [US_W-1:0]   undersamp,
   input  logic              FIFO_full,
   output logic              owrreq,
   output logic [DATA_W-1:0] data_out,
   output logic [NUM_CH-1:0] stop_out,
   output logic [DROP_W-1:0] drop_count
);

   // The gap counter only needs enough range to reach MIN_GAP, after which it
   // just sits saturated.
   localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
   localparam logic [CNT_W-1:0]  PER_MAX  = '1;
   localparam logic [GAP_W-1:0]  GAP_MAX  = '1;
   localparam logic [GAP_W-1:0]  GAP_MIN  = GAP_W'(MIN_GAP);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [NUM_CH-1:0] s1_q, s2_q, s3_q;
   logic [NUM_CH-1:0] armed_q, armed_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] stop_q;
   logic [NUM_CH-1:0] edgeDet, accept, emit, grantVec;
   logic [GAP_W-1:0]  gapCnt_q [NUM_CH];
   logic [GAP_W-1:0]  gapCnt_d [NUM_CH];
   logic [CNT_W-1:0]  perCnt_q [NUM_CH];
   logic [CNT_W-1:0]  perCnt_d [NUM_CH];
   logic [US_W-1:0]   usCnt_q  [NUM_CH];
   logic [US_W-1:0]   usCnt_d  [NUM_CH];
   logic [DATA_W-1:0] hold_q   [NUM_CH];
   logic [DATA_W-1:0] hold_d   [NUM_CH];
   logic [CH_BITS-1:0] ptr_q, ptr_d, grant, scanIdx;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               found;

   // Round-robin arbiter: first pending channel at or above the pointer wins.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      scanIdx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scanIdx = CH_BITS'((int'(ptr_q) + k) % NUM_CH);
         if (!found && pend_q[scanIdx]) begin
            found = 1'b1;
            grant = scanIdx;
         end
      end
      owrreq   = found & ~FIFO_full;
      data_out = owrreq ? hold_q[grant] : '0;
      ptr_d    = ptr_q;
      if (owrreq) begin
         ptr_d = CH_BITS'((int'(grant) + 1) % NUM_CH);
      end
   end

   // Per-channel edge acceptance, arming, undersampling and period counting.
   always_comb begin
      edgeDet = s2_q & ~s3_q;
      accept  = '0;
      emit    = '0;
      armed_d = armed_q;
      for (int i = 0; i < NUM_CH; i++) begin
         gapCnt_d[i] = gapCnt_q[i];
         perCnt_d[i] = perCnt_q[i];
         usCnt_d[i]  = usCnt_q[i];
         if (!ENABLE) begin
            armed_d[i]  = 1'b0;
            gapCnt_d[i] = '0;
            perCnt_d[i] = '0;
            usCnt_d[i]  = '0;
         end else begin
            accept[i]   = edgeDet[i] & (~armed_q[i] | (gapCnt_q[i] >= GAP_MIN));
            gapCnt_d[i] = (gapCnt_q[i] == GAP_MAX) ? gapCnt_q[i] : gapCnt_q[i] + GAP_W'(1);
            perCnt_d[i] = (perCnt_q[i] == PER_MAX) ? perCnt_q[i] : perCnt_q[i] + CNT_W'(1);
            if (accept[i]) begin
               gapCnt_d[i] = GAP_W'(1);
               if (!armed_q[i]) begin
                  armed_d[i]  = 1'b1;
                  perCnt_d[i] = CNT_W'(1);
                  usCnt_d[i]  = '0;
               end else if (usCnt_q[i] == undersamp) begin
                  emit[i]     = 1'b1;
                  perCnt_d[i] = CNT_W'(1);
                  usCnt_d[i]  = '0;
               end else begin
                  usCnt_d[i]  = usCnt_q[i] + US_W'(1);
               end
            end
         end
      end
   end

   // Holding registers: a granted slot frees up in the same cycle it can be
   // refilled; a new record for a still-occupied slot is dropped and counted.
   always_comb begin
      drop_d   = drop_q;
      pend_d   = pend_q;
      grantVec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hold_d[i]   = hold_q[i];
         grantVec[i] = owrreq && (grant == CH_BITS'(i));
         pend_d[i]   = pend_q[i] & ~grantVec[i];
         if (emit[i]) begin
            if (pend_q[i] && !grantVec[i]) begin
               if (drop_d != DROP_MAX) begin
                  drop_d = drop_d + DROP_W'(1);
               end
            end else begin
               pend_d[i] = 1'b1;
               hold_d[i] = {CH_BITS'(i), (perCnt_q[i] == PER_MAX), perCnt_q[i]};
            end
         end
      end
   end

   // State registers. The synchronisers are cleared too so that no phantom
   // edge appears right after reset.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         armed_q <= '0;
         pend_q  <= '0;
         stop_q  <= '0;
         ptr_q   <= '0;
         drop_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            gapCnt_q[i] <= '0;
            perCnt_q[i] <= '0;
            usCnt_q[i]  <= '0;
            hold_q[i]   <= '0;
         end
      end else begin
         s1_q    <= ChA;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         armed_q <= armed_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
         for (int i = 0; i < NUM_CH; i++) begin
            stop_q[i]   <= (perCnt_q[i] == PER_MAX) & armed_q[i];
            gapCnt_q[i] <= gapCnt_d[i];
            perCnt_q[i] <= perCnt_d[i];
            usCnt_q[i]  <= usCnt_d[i];
            hold_q[i]   <= hold_d[i];
         end
      end
   end

   assign stop_out   = stop_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_multi_channel_period_counter.sv
// Bench for multi_channel_period_counter: an event-level model predicts every
// output each cycle, and directed literals pin the key records.
module tb_multi_channel_period_counter;

   localparam int NUM_CH  = 4;
   localparam int MIN_GAP = 100;
   localparam int PER_MAX = 65535;
   localparam int CH_MUL  = 131072;
   localparam int SAT_MUL = 65536;

   logic        CLOCK_50 = 1'b0;
   logic        RESET;
   logic        ENABLE;
   logic [3:0]  ChA;
   logic [2:0]  undersamp;
   logic        FIFO_full;
   logic        owrreq;
   logic [18:0] data_out;
   logic [3:0]  stop_out;
   logic [15:0] drop_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mValid = 1'b0;

   int          dueQ [NUM_CH][$];
   bit          mArmed   [NUM_CH];
   int          mLastAcc [NUM_CH];
   int          mRef     [NUM_CH];
   int          mUs      [NUM_CH];
   bit          mPend    [NUM_CH];
   logic [18:0] mHold    [NUM_CH];
   bit          mStop    [NUM_CH];
   int          mPtr;
   int          mDrop;
   logic [18:0] recLog[$];
   int          recCyc[$];

   int          mG, cG, period;
   bit          mOwr, cOwr, edgeSeen;
   logic [18:0] cData;
   logic [3:0]  cStop;

   always #5 CLOCK_50 = ~CLOCK_50;

   multi_channel_period_counter dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .ENABLE     (ENABLE),
      .ChA        (ChA),
      .undersamp  (undersamp),
      .FIFO_full  (FIFO_full),
      .owrreq     (owrreq),
      .data_out   (data_out),
      .stop_out   (stop_out),
      .drop_count (drop_count)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pickGrant();
      for (int k = 0; k < NUM_CH; k++) begin
         if (mPend[(mPtr + k) % NUM_CH]) return (mPtr + k) % NUM_CH;
      end
      return -1;
   endfunction

   // Model: edges arrive three cycles after the input rises; periods are
   // differences of cycle numbers between reference edges.
   initial forever begin
      @(posedge CLOCK_50);
      cyc++;
      mG   = pickGrant();
      mOwr = (mG >= 0) && !FIFO_full;
      if (RESET) begin
         mValid = 1'b1;
         mPtr   = 0;
         mDrop  = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            mArmed[i] = 1'b0;
            mUs[i]    = 0;
            mPend[i]  = 1'b0;
            mHold[i]  = '0;
            mStop[i]  = 1'b0;
            while (dueQ[i].size() > 0 && dueQ[i][0] <= cyc) void'(dueQ[i].pop_front());
         end
      end else begin
         if (mOwr) begin
            mPend[mG] = 1'b0;
            mPtr      = (mG + 1) % NUM_CH;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            mStop[i] = mArmed[i] && ((cyc - mRef[i]) >= PER_MAX);
            edgeSeen = 1'b0;
            while (dueQ[i].size() > 0 && dueQ[i][0] <= cyc) begin
               if (dueQ[i][0] == cyc) edgeSeen = 1'b1;
               void'(dueQ[i].pop_front());
            end
            if (!ENABLE) begin
               mArmed[i] = 1'b0;
            end else if (edgeSeen && (!mArmed[i] || (cyc - mLastAcc[i]) >= MIN_GAP)) begin
               mLastAcc[i] = cyc;
               if (!mArmed[i]) begin
                  mArmed[i] = 1'b1;
                  mRef[i]   = cyc;
                  mUs[i]    = 0;
               end else if (mUs[i] == int'(undersamp)) begin
                  period = cyc - mRef[i];
                  if (period > PER_MAX) period = PER_MAX;
                  mRef[i] = cyc;
                  mUs[i]  = 0;
                  if (mPend[i]) begin
                     if (mDrop < 65535) mDrop++;
                  end else begin
                     mPend[i] = 1'b1;
                     mHold[i] = 19'(i * CH_MUL + ((period == PER_MAX) ? SAT_MUL : 0) + period);
                  end
               end else begin
                  mUs[i] = (mUs[i] + 1) % 8;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of written records.
   initial forever begin
      @(negedge CLOCK_50);
      if (mValid) begin
         cG    = pickGrant();
         cOwr  = (cG >= 0) && !FIFO_full;
         cData = cOwr ? mHold[cG] : '0;
         for (int i = 0; i < NUM_CH; i++) cStop[i] = mStop[i];
         checkOutput("owrreq", 32'(owrreq), 32'(cOwr));
         checkOutput("data_out", 32'(data_out), 32'(cData));
         checkOutput("stop_out", 32'(stop_out), 32'(cStop));
         checkOutput("drop_count", 32'(drop_count), 32'(mDrop));
      end
      if (owrreq) begin
         recLog.push_back(data_out);
         recCyc.push_back(cyc);
      end
   end

   task automatic waitUntil(input int t);
      while (cyc < t) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Raise the selected inputs just after posedge t, drop them two cycles later.
   task automatic applyStimulus(input int t, input logic [3:0] mask);
      waitUntil(t);
      ChA = ChA | mask;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i]) dueQ[i].push_back(t + 3);
      end
      waitUntil(t + 2);
      ChA = ChA & ~mask;
   endtask

   task automatic checkRecord(input string name, input int idx, input int exp);
      checkOutput(name, (idx < recLog.size()) ? 32'(recLog[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask

   task automatic checkRecCycle(input string name, input int idx, input int exp);
      checkOutput(name, (idx < recCyc.size()) ? 32'(recCyc[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b0; ChA = '0; undersamp = '0; FIFO_full = 1'b0;
      waitUntil(2);
      checkOutput("reset owrreq", 32'(owrreq), 0);
      checkOutput("reset data_out", 32'(data_out), 0);
      checkOutput("reset stop_out", 32'(stop_out), 0);
      checkOutput("reset drop_count", 32'(drop_count), 0);
      waitUntil(3);
      RESET = 1'b0; ENABLE = 1'b1;

      // Channel 0, period 1000: first edge only arms
      applyStimulus(100, 4'b0001);
      applyStimulus(1100, 4'b0001);
      applyStimulus(2100, 4'b0001);
      waitUntil(2200);
      checkRecord("t1 rec0", 0, 1000);
      checkRecord("t1 rec1", 1, 1000);
      checkRecCycle("t1 latency", 1, 2103);

      // Channel 1 with a glitch 50 cycles after the arming edge
      applyStimulus(3000, 4'b0010);
      applyStimulus(3050, 4'b0010);
      applyStimulus(4000, 4'b0010);
      waitUntil(4100);
      checkRecord("t2 rec", 2, CH_MUL + 1000);
      checkOutput("t2 count", 32'(recLog.size()), 3);

      // Channel 2, undersample 2, period 500
      undersamp = 3'd2;
      for (int k = 0; k < 7; k++) applyStimulus(5000 + 500 * k, 4'b0100);
      waitUntil(8100);
      checkRecord("t3 rec a", 3, 2 * CH_MUL + 1500);
      checkRecord("t3 rec b", 4, 2 * CH_MUL + 1500);
      undersamp = 3'd0;

      // Channel 3, 70000-cycle period saturates
      applyStimulus(9000, 4'b1000);
      waitUntil(74537);
      checkOutput("t4 stop early", 32'(stop_out[3]), 0);
      waitUntil(74538);
      checkOutput("t4 stop set", 32'(stop_out[3]), 1);
      applyStimulus(79000, 4'b1000);
      waitUntil(79005);
      checkOutput("t4 stop clear", 32'(stop_out[3]), 0);
      checkRecord("t4 rec", 5, 3 * CH_MUL + SAT_MUL + PER_MAX);

      // All four channels emit together
      applyStimulus(80000, 4'b1111);
      waitUntil(80010);
      checkRecord("t5 ch0", 6, SAT_MUL + PER_MAX);
      checkRecord("t5 ch1", 7, CH_MUL + SAT_MUL + PER_MAX);
      checkRecord("t5 ch2", 8, 2 * CH_MUL + SAT_MUL + PER_MAX);
      checkRecord("t5 ch3", 9, 3 * CH_MUL + 1000);
      checkRecCycle("t5 first cycle", 6, 80003);
      checkRecCycle("t5 last cycle", 9, 80006);

      // FIFO full with a second emission while the first is pending
      waitUntil(81000);
      FIFO_full = 1'b1;
      applyStimulus(81100, 4'b0001);
      applyStimulus(82300, 4'b0001);
      waitUntil(82400);
      checkOutput("t5 drop", 32'(drop_count), 1);
      waitUntil(82900);
      checkOutput("t5 held count", 32'(recLog.size()), 10);
      checkOutput("t5 held owrreq", 32'(owrreq), 0);
      waitUntil(83000);
      FIFO_full = 1'b0;
      waitUntil(83010);
      checkRecord("t5 drained", 10, 1100);

      // Reset with a record pending; it must be discarded
      waitUntil(83400);
      FIFO_full = 1'b1;
      applyStimulus(83500, 4'b0010);
      waitUntil(84000);
      RESET = 1'b1;
      waitUntil(84001);
      RESET = 1'b0;
      checkOutput("t6 owrreq", 32'(owrreq), 0);
      checkOutput("t6 data_out", 32'(data_out), 0);
      checkOutput("t6 stop_out", 32'(stop_out), 0);
      checkOutput("t6 drop_count", 32'(drop_count), 0);
      waitUntil(84005);
      FIFO_full = 1'b0;
      waitUntil(84050);
      checkOutput("t6 discarded", 32'(recLog.size()), 11);
      applyStimulus(84100, 4'b0010);
      applyStimulus(84700, 4'b0010);
      waitUntil(84710);
      checkRecord("t6 rec", 11, CH_MUL + 600);

      // ENABLE low disarms; the next edge after it rises only arms
      waitUntil(84800);
      ENABLE = 1'b0;
      applyStimulus(84900, 4'b0010);
      waitUntil(85000);
      ENABLE = 1'b1;
      applyStimulus(85100, 4'b0010);
      applyStimulus(85400, 4'b0010);
      waitUntil(85500);
      checkRecord("t7 rec", 12, CH_MUL + 300);
      checkOutput("t7 count", 32'(recLog.size()), 13);

      waitUntil(85600);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
